// File: rtl/arcade_cab_input.sv
// Cabinet-input conditioner: hps_io joystick words to active-low arcade controls.
// Define ARCADE_CAB_INPUT_DEBOUNCE_EN to add a stability filter ahead of the input register.
module arcade_cab_input #(
  parameter int PLAYERS         = 2,
  parameter int COIN_CYCLES     = 120000,
  parameter int BLINK_CYCLES    = 3000000,
  parameter int DEBOUNCE_CYCLES = 24000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [16*PLAYERS-1:0] joystick,
  input  logic                  swap_cs,
  input  logic [PLAYERS-1:0]    credit,
  output logic [4*PLAYERS-1:0]  dir_n,
  output logic [PLAYERS-1:0]    coin_n,
  output logic                  start1_n,
  output logic                  start2_n,
  output logic [PLAYERS-1:0]    lamp
);
  localparam int CW = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] COIN_LAST  = CW'(COIN_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} coin_state_e;

  // Only bits 0..6 of each player word are used: 7 bits per player internally.
  logic [7*PLAYERS-1:0] raw_s;
  logic [7*PLAYERS-1:0] filt_s;
  logic [7*PLAYERS-1:0] j_in_s;
  logic [7*PLAYERS-1:0] j_q_r;
  logic [PLAYERS-1:0]   coin_prev_r;
  logic [PLAYERS-1:0]   coin_edge_s;
  logic [4*PLAYERS-1:0] dir_s;
  logic                 start1_s;
  logic                 start2_s;
  logic                 unused_hi_s;
  logic [BW-1:0]        blink_cnt_r;
  logic                 phase_r;

  // Gather the used bits of every player word
  always_comb begin
    raw_s       = '0;
    unused_hi_s = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      raw_s[7*p +: 7] = joystick[16*p +: 7];
      unused_hi_s     = unused_hi_s ^ (^joystick[16*p+7 +: 9]);
    end
  end

`ifdef ARCADE_CAB_INPUT_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [DW-1:0]        deb_cnt_r [7*PLAYERS];
  logic [7*PLAYERS-1:0] filt_r;

  // A raw bit replaces the filtered bit once it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < 7*PLAYERS; i++) begin
      if (reset) begin
        deb_cnt_r[i] <= '0;
        filt_r[i]    <= 1'b0;
      end else if (raw_s[i] == filt_r[i]) begin
        deb_cnt_r[i] <= '0;
      end else if (deb_cnt_r[i] == DEB_LAST) begin
        deb_cnt_r[i] <= '0;
        filt_r[i]    <= raw_s[i];
      end else begin
        deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
      end
    end
  end
  assign filt_s = filt_r;
`else
  assign filt_s = raw_s;
`endif

  // Coin/start exchange applied ahead of the input register
  always_comb begin
    j_in_s = filt_s;
    for (int p = 0; p < PLAYERS; p++) begin
      if (swap_cs) begin
        j_in_s[7*p+4] = filt_s[7*p+5];
        j_in_s[7*p+5] = filt_s[7*p+4];
      end else begin
        j_in_s[7*p+4] = filt_s[7*p+4];
        j_in_s[7*p+5] = filt_s[7*p+5];
      end
    end
  end

  // Input register and previous coin level for edge detection
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      j_q_r       <= '0;
      coin_prev_r <= '0;
    end else begin
      j_q_r <= j_in_s;
      for (int p = 0; p < PLAYERS; p++) begin
        coin_prev_r[p] <= j_q_r[7*p+4];
      end
    end
  end

  // SOCD cleaning, start OR-reduction and coin edge detection
  always_comb begin
    dir_s       = '0;
    start1_s    = 1'b0;
    start2_s    = 1'b0;
    coin_edge_s = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      dir_s[4*p+0]   = j_q_r[7*p+0] & ~j_q_r[7*p+1];
      dir_s[4*p+1]   = j_q_r[7*p+1] & ~j_q_r[7*p+0];
      dir_s[4*p+2]   = j_q_r[7*p+2] & ~j_q_r[7*p+3];
      dir_s[4*p+3]   = j_q_r[7*p+3] & ~j_q_r[7*p+2];
      start1_s       = start1_s | j_q_r[7*p+5];
      start2_s       = start2_s | j_q_r[7*p+6];
      coin_edge_s[p] = j_q_r[7*p+4] & ~coin_prev_r[p];
    end
  end

  // Registered direction and start outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir_n    <= '1;
      start1_n <= 1'b1;
      start2_n <= 1'b1;
    end else begin
      dir_n    <= ~dir_s;
      start1_n <= ~start1_s;
      start2_n <= ~start2_s;
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < PLAYERS; gp++) begin : g_coin
      coin_state_e   state_r;
      logic [CW-1:0] cnt_r;
      logic [1:0]    pend_r;
      logic          coin_q_r;

      // Coin pulse shaper; presses during a pulse or gap queue up to three deep
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          state_r  <= IDLE;
          cnt_r    <= '0;
          pend_r   <= 2'd0;
          coin_q_r <= 1'b1;
        end else begin
          case (state_r)
            IDLE: begin
              if (coin_edge_s[gp] || (pend_r != 2'd0)) begin
                state_r  <= PULSE;
                cnt_r    <= '0;
                coin_q_r <= 1'b0;
                if (!coin_edge_s[gp]) begin
                  pend_r <= pend_r - 2'd1;
                end
              end
            end
            PULSE: begin
              if (coin_edge_s[gp] && (pend_r != 2'd3)) begin
                pend_r <= pend_r + 2'd1;
              end
              if (cnt_r == COIN_LAST) begin
                state_r  <= GAP;
                cnt_r    <= '0;
                coin_q_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end
            GAP: begin
              if (coin_edge_s[gp] && (pend_r != 2'd3)) begin
                pend_r <= pend_r + 2'd1;
              end
              if (cnt_r == COIN_LAST) begin
                state_r <= IDLE;
                cnt_r   <= '0;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end
            default: begin
              state_r  <= IDLE;
              cnt_r    <= '0;
              coin_q_r <= 1'b1;
            end
          endcase
        end
      end

      assign coin_n[gp] = coin_q_r;
    end
  endgenerate

  // Shared blink phase and per-player lamp gating
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
      lamp        <= '0;
    end else begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= '0;
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
      end
      lamp <= credit & {PLAYERS{phase_r}};
    end
  end
endmodule

// File: tb/tb_arcade_cab_input.sv
// Scoreboard bench for arcade_cab_input: a schedule-based reference model predicts every output cycle.
module tb_arcade_cab_input;
  localparam int P   = 2;
  localparam int C   = 4;
  localparam int B   = 8;
  localparam int PER = 2*C + 1;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [31:0]   joystick;
  logic          swap_cs;
  logic [1:0]    credit;
  logic [7:0]    dir_n;
  logic [1:0]    coin_n;
  logic          start1_n;
  logic          start2_n;
  logic [1:0]    lamp;

  always #5 clk_sys = ~clk_sys;

  arcade_cab_input #(
    .PLAYERS(P), .COIN_CYCLES(C), .BLINK_CYCLES(B), .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .joystick(joystick), .swap_cs(swap_cs),
    .credit(credit), .dir_n(dir_n), .coin_n(coin_n), .start1_n(start1_n),
    .start2_n(start2_n), .lamp(lamp)
  );

  typedef struct packed {
    logic [7:0] dir_n;
    logic [1:0] coin_n;
    logic       s1_n;
    logic       s2_n;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] lamp_q[$];
  int         sched [P][$];   // absolute start index of every accepted coin pulse
  logic [P-1:0] prev_coin;
  int checks = 0;
  int passed = 0;
  int n      = 0;
  int mcyc   = 0;
  bit mon_go   = 1'b0;
  bit stim_done = 1'b0;
  bit mon_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, mcyc, got, want);
  endtask

  // Active-high {up,down,left,right}; an axis pressed both ways cancels.
  function automatic logic [3:0] dir_active(input logic [3:0] b);
    logic [3:0] a;
    a = b;
    if (int'(b[0]) + int'(b[1]) == 2) a[1:0] = 2'b00;
    if (int'(b[2]) + int'(b[3]) == 2) a[3:2] = 2'b00;
    return a;
  endfunction

  // Drive one cycle of inputs and queue the outputs they must produce.
  task automatic step(input logic [31:0] joy, input logic sw, input logic [1:0] cr);
    exp_t e;
    logic [15:0] w;
    logic coin_bit;
    int future, st, last;
    joystick = joy;
    swap_cs  = sw;
    credit   = cr;
    e.s1_n = 1'b1;
    e.s2_n = 1'b1;
    for (int p = 0; p < P; p++) begin
      w = joy[16*p +: 16];
      e.dir_n[4*p +: 4] = ~dir_active(w[3:0]);
      coin_bit = sw ? w[5] : w[4];
      if (sw ? w[4] : w[5]) e.s1_n = 1'b0;
      if (w[6]) e.s2_n = 1'b0;
      if (coin_bit && !prev_coin[p]) begin
        future = 0;
        for (int i = 0; i < sched[p].size(); i++) if (sched[p][i] > n) future++;
        if (future < 3) begin
          st = n;
          if (sched[p].size() > 0) begin
            last = sched[p][sched[p].size()-1];
            if (last + PER > st) st = last + PER;
          end
          sched[p].push_back(st);
        end
      end
      prev_coin[p] = coin_bit;
      while (sched[p].size() > 1 && sched[p][0] + C <= n) void'(sched[p].pop_front());
      e.coin_n[p] = 1'b1;
      for (int i = 0; i < sched[p].size(); i++)
        if (sched[p][i] <= n && n < sched[p][i] + C) e.coin_n[p] = 1'b0;
    end
    exp_q.push_back(e);
    lamp_q.push_back(cr & {2{((n / B) % 2) == 1}});
    @(posedge clk_sys);
    #1;
    n++;
  endtask

  // Monitor: one expected entry per output cycle, popped on the falling edge.
  initial begin
    exp_t e;
    logic [1:0] le;
    wait (mon_go);
    while (!(stim_done && exp_q.size() == 0)) begin
      @(negedge clk_sys);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dir_n", 32'(dir_n), 32'(e.dir_n));
        chk("coin_n", 32'(coin_n), 32'(e.coin_n));
        chk("start1_n", 32'(start1_n), 32'(e.s1_n));
        chk("start2_n", 32'(start2_n), 32'(e.s2_n));
      end
      if (lamp_q.size() > 0) begin
        le = lamp_q.pop_front();
        chk("lamp", 32'(lamp), 32'(le));
      end
      mcyc++;
    end
    mon_done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", mcyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] j;
    logic        sw;
    logic [1:0]  cr;
    reset     = 1'b1;
    joystick  = '1;
    swap_cs   = 1'b0;
    credit    = 2'b11;
    prev_coin = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk("rst_dir_n", 32'(dir_n), 32'hFF);
      chk("rst_coin_n", 32'(coin_n), 32'h3);
      chk("rst_start1_n", 32'(start1_n), 32'h1);
      chk("rst_start2_n", 32'(start2_n), 32'h1);
      chk("rst_lamp", 32'(lamp), 32'h0);
    end
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    exp_q.push_back({8'hFF, 2'b11, 1'b1, 1'b1});
    exp_q.push_back({8'hFF, 2'b11, 1'b1, 1'b1});
    lamp_q.push_back(2'b00);
    mon_go = 1'b1;

    repeat (3) step(32'hFFFF_FFFF, 1'b0, 2'b00);
    repeat (3) step(32'h0000_0009, 1'b0, 2'b00);
    repeat (3) step(32'h0000_000B, 1'b0, 2'b00);
    repeat (6) step(32'h0000_0000, 1'b0, 2'b00);
    step(32'h0010_0000, 1'b0, 2'b00);
    repeat (12) step(32'h0000_0000, 1'b0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      step(32'h0000_0010, 1'b0, 2'b00);
      step(32'h0000_0000, 1'b0, 2'b00);
    end
    repeat (40) step(32'h0000_0000, 1'b0, 2'b00);
    step(32'h0000_0020, 1'b1, 2'b00);
    repeat (12) step(32'h0000_0000, 1'b1, 2'b00);
    repeat (4) step(32'h0010_0000, 1'b1, 2'b00);
    repeat (40) step(32'h0000_0000, 1'b0, 2'b01);
    repeat (4) step(32'h0000_0000, 1'b0, 2'b00);

    sw = 1'b0;
    cr = 2'b00;
    repeat (300) begin
      j = $urandom;
      if ($urandom_range(0, 5) != 0) j = j & ~32'h0030_0030;
      if ($urandom_range(0, 31) == 0) sw = ~sw;
      if ($urandom_range(0, 15) == 0) cr = 2'($urandom);
      step(j, sw, cr);
    end
    repeat (30) step(32'h0000_0000, 1'b0, 2'b00);

    stim_done = 1'b1;
    for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk_sys);
    if (!mon_done) begin
      checks++;
      $display("FAIL monitor_drain cyc=%0d got=%0d exp=0", mcyc, exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
